// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
//   state_e    : FSM state with fixed debug encodings 0..5
//   bits_for() : counter width needed to hold a given maximum value
//   max_of()   : integer max, used to size the shared phase counter
//   LOSS_CNT_W : width of the optional lock-loss counter
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  localparam int LOSS_CNT_W = 16;

  function automatic int bits_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync.sv
// sync_bit: SYNC_STAGES-deep flop chain bringing an asynchronous level into
// the clk domain. Latency is SYNC_STAGES cycles; all flops clear to 0.
//   clk   in  sampling clock
//   rst_n in  async active-low reset
//   d     in  asynchronous input
//   q     out synchronised output
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, qualifies the synchronised lock,
// retries on lock timeout, then releases NUM_CH domain resets in a staggered
// order. Lock loss or soft_rst tears everything back down.
//   refclk        in  sole clock
//   rst_n         in  async active-low reset
//   pll_locked    in  raw PLL lock (asynchronous)
//   soft_rst      in  synchronous restart request
//   pll_rst       out active-high PLL reset
//   domain_rst_n  out per-domain active-low resets, bit 0 released first
//   locked        out qualified lock
//   fault         out retry budget exhausted
//   state         out FSM state encoding (debug)
//   retry_cnt     out failed attempts since last qualified lock
//   lock_loss_cnt out saturating lock-loss teardown count
//                     (only with PLL_RESET_SEQUENCER_LOSS_CNT_EN defined)
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int STAGGER_CYC      = 8,
  parameter int MAX_RETRY        = 3,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                           refclk,
  input  logic                           rst_n,
  input  logic                           pll_locked,
  input  logic                           soft_rst,
  output logic                           pll_rst,
  output logic [NUM_CH-1:0]              domain_rst_n,
  output logic                           locked,
  output logic                           fault,
  output logic [2:0]                     state,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0]          lock_loss_cnt
`endif
);

  localparam int RW       = $clog2(MAX_RETRY + 1);
  localparam int REL_LAST = (NUM_CH - 1) * STAGGER_CYC;
  // One counter serves every phase; it is cleared on each state entry.
  localparam int CNT_MAX  = max_of(max_of(PLL_RST_CYC - 1, LOCK_STABLE_CYC - 1),
                                   max_of(LOCK_TIMEOUT_CYC - 1, REL_LAST));
  localparam int CW       = bits_for(CNT_MAX);

  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] REL_END   = CW'(REL_LAST);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0]       retry_q, retry_d, retry_inc;
  logic                pll_rst_q, pll_rst_d;
  logic                locked_q, locked_d;
  logic                fault_q, fault_d;
  logic [NUM_CH-1:0]   dom_q, dom_d;
  logic                lock_s;
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
  logic                loss_evt;
`endif

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_comb begin
    cnt_inc   = cnt_q + 1'b1;
    retry_inc = retry_q + 1'b1;
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    pll_rst_d = pll_rst_q;
    locked_d  = locked_q;
    fault_d   = fault_q;
    dom_d     = dom_q;
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    loss_evt  = 1'b0;
`endif
    if (soft_rst) begin
      state_d   = ST_PLL_RST;
      cnt_d     = '0;
      retry_d   = '0;
      pll_rst_d = 1'b1;
      locked_d  = 1'b0;
      fault_d   = 1'b0;
      dom_d     = '0;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d   = ST_WAIT_LOCK;
            cnt_d     = '0;
            pll_rst_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            retry_d   = retry_inc;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            if (retry_inc == RETRY_MAX) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end else begin
              state_d = ST_PLL_RST;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_STABLE: begin
          // Any drop restarts the timeout window rather than retrying.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d  = ST_RELEASE;
            cnt_d    = '0;
            locked_d = 1'b1;
            retry_d  = '0;
            dom_d    = NUM_CH'(1);
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!lock_s) begin
            state_d   = ST_PLL_RST;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            locked_d  = 1'b0;
            dom_d     = '0;
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
            loss_evt  = 1'b1;
`endif
          end else if (state_q == ST_RELEASE) begin
            if (cnt_q == REL_END) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end else begin
              // Bit i is high from the cycle whose count equals i*STAGGER_CYC.
              cnt_d = cnt_inc;
              for (int i = 1; i < NUM_CH; i++)
                if (cnt_inc >= CW'(i * STAGGER_CYC)) dom_d[i] = 1'b1;
            end
          end
        end
        ST_FAULT: ;
        default: begin
          state_d   = ST_PLL_RST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          locked_d  = 1'b0;
          dom_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      locked_q  <= 1'b0;
      fault_q   <= 1'b0;
      dom_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      locked_q  <= locked_d;
      fault_q   <= fault_d;
      dom_q     <= dom_d;
    end
  end

`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
  // Survives soft_rst so lock drops stay visible across restarts.
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (loss_evt && (loss_q != '1)) loss_d = loss_q + 1'b1;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) loss_q <= '0;
    else        loss_q <= loss_d;
  end

  assign lock_loss_cnt = loss_q;
`endif

  assign pll_rst      = pll_rst_q;
  assign domain_rst_n = dom_q;
  assign locked       = locked_q;
  assign fault        = fault_q;
  assign state        = state_q;
  assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed bring-up / timeout / glitch /
// lock-loss / soft-reset scenarios followed by randomized lock and soft_rst
// traffic, all checked every cycle against a phase/elapsed-time reference.
module tb_pll_reset_sequencer;

  localparam int NUM_CH = 3, PLL_RST_CYC = 4, LOCK_STABLE_CYC = 8;
  localparam int LOCK_TIMEOUT_CYC = 32, STAGGER_CYC = 3, MAX_RETRY = 2;
  localparam int SYNC_STAGES = 2;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_REL = 3, P_RUN = 4, P_FAULT = 5;

  logic refclk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, soft_rst = 1'b0;
  logic pll_rst, locked, fault;
  logic [NUM_CH-1:0] domain_rst_n;
  logic [2:0] state;
  logic [RW-1:0] retry_cnt;
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
  logic [15:0] lock_loss_cnt;
`endif

  pll_reset_sequencer #(
    .NUM_CH(NUM_CH), .PLL_RST_CYC(PLL_RST_CYC), .LOCK_STABLE_CYC(LOCK_STABLE_CYC),
    .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC), .STAGGER_CYC(STAGGER_CYC),
    .MAX_RETRY(MAX_RETRY), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_rst(soft_rst),
    .pll_rst(pll_rst), .domain_rst_n(domain_rst_n), .locked(locked), .fault(fault),
    .state(state), .retry_cnt(retry_cnt)
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    , .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 refclk = ~refclk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: which phase we are in and how many cycles it has lasted.
  int m_ph, m_t, m_retry, m_loss;
  logic [SYNC_STAGES-1:0] m_sh;

  task automatic m_reset();
    m_ph = P_RST; m_t = 0; m_retry = 0; m_loss = 0; m_sh = '0;
  endtask

  task automatic m_go(input int p);
    m_ph = p; m_t = 0;
  endtask

  task automatic m_step();
    logic ls;
    ls = m_sh[SYNC_STAGES-1];
    if (!rst_n) begin m_reset(); return; end
    if (soft_rst) begin
      m_go(P_RST); m_retry = 0;
    end else begin
      case (m_ph)
        P_RST:    if (m_t == PLL_RST_CYC - 1) m_go(P_WAIT); else m_t++;
        P_WAIT:
          if (ls) m_go(P_STABLE);
          else if (m_t == LOCK_TIMEOUT_CYC - 1) begin
            m_retry++;
            m_go(m_retry == MAX_RETRY ? P_FAULT : P_RST);
          end else m_t++;
        P_STABLE:
          if (!ls) m_go(P_WAIT);
          else if (m_t == LOCK_STABLE_CYC - 1) begin m_go(P_REL); m_retry = 0; end
          else m_t++;
        P_REL, P_RUN:
          if (!ls) begin
            m_go(P_RST);
            if (m_loss < 16'hFFFF) m_loss++;
          end else if (m_ph == P_REL) begin
            if (m_t == (NUM_CH - 1) * STAGGER_CYC) m_go(P_RUN); else m_t++;
          end
        default: ;
      endcase
    end
    m_sh = {m_sh[SYNC_STAGES-2:0], pll_locked};
  endtask

  // Expected outputs packed {state, pll_rst, locked, fault, retry, domains}.
  function automatic logic [31:0] m_out();
    logic [NUM_CH-1:0] d;
    logic pr, lk, ft;
    d = '0;
    for (int i = 0; i < NUM_CH; i++)
      d[i] = (m_ph == P_RUN) || (m_ph == P_REL && m_t >= i * STAGGER_CYC);
    pr = (m_ph == P_RST) || (m_ph == P_FAULT);
    lk = (m_ph == P_REL) || (m_ph == P_RUN);
    ft = (m_ph == P_FAULT);
    return 32'({3'(m_ph), pr, lk, ft, RW'(m_retry), d});
  endfunction

  task automatic tick();
    @(posedge refclk);
    m_step();
    @(negedge refclk);
    chk("cyc", 32'({state, pll_rst, locked, fault, retry_cnt, domain_rst_n}), m_out());
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    chk("loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
`endif
  endtask

  task automatic wait_ph(input int p, input int t, input string tag);
    for (int k = 0; k < 200 && !(m_ph == p && m_t == t); k++) tick();
    chk(tag, 32'(state), 32'(p));
  endtask

  localparam int ALL_ON = (1 << NUM_CH) - 1;
  int exp_loss;
  int run_left;

  initial begin
    m_reset();
    repeat (3) tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_dom", 32'(domain_rst_n), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_retry", 32'(retry_cnt), 0);

    // Bring-up: lock rises at cycle 10.
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 10) pll_locked = 1'b1;
      tick();
      if (c < 8) chk("bringup_pll_rst", 32'(pll_rst), 32'((c + 1) < PLL_RST_CYC));
    end
    chk("bringup_state", 32'(state), P_RUN);
    chk("bringup_dom", 32'(domain_rst_n), ALL_ON);
    chk("bringup_locked", 32'(locked), 1);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    repeat (SYNC_STAGES) tick();
    chk("loss_hold", 32'(state), P_RUN);
    tick();
    chk("loss_state", 32'(state), P_RST);
    chk("loss_dom", 32'(domain_rst_n), 0);
    chk("loss_pll_rst", 32'(pll_rst), 1);
    chk("loss_retry", 32'(retry_cnt), 0);
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    chk("loss_cnt_1", 32'(lock_loss_cnt), 1);
`endif

    // Timeout retries into FAULT.
    wait_ph(P_FAULT, 0, "to_reach_fault");
    chk("to_fault", 32'(fault), 1);
    chk("to_retry", 32'(retry_cnt), MAX_RETRY);
    chk("to_pll_rst", 32'(pll_rst), 1);
    repeat (10) tick();
    chk("fault_sticky", 32'(state), P_FAULT);

    // Soft reset out of FAULT, then a normal bring-up.
    soft_rst = 1'b1; tick(); soft_rst = 1'b0;
    chk("soft_fault", 32'(fault), 0);
    chk("soft_retry", 32'(retry_cnt), 0);
    chk("soft_state", 32'(state), P_RST);
    pll_locked = 1'b1;
    wait_ph(P_RUN, 0, "soft_bringup");

    // Glitchy lock: lock_s drops after 5 good STABLE cycles.
    soft_rst = 1'b1; pll_locked = 1'b0; tick(); soft_rst = 1'b0;
    wait_ph(P_WAIT, 0, "glitch_wait");
    pll_locked = 1'b1;
    wait_ph(P_STABLE, 3, "glitch_stable");
    pll_locked = 1'b0; tick();
    pll_locked = 1'b1; tick(); tick();
    chk("glitch_state", 32'(state), P_WAIT);
    chk("glitch_locked", 32'(locked), 0);
    chk("glitch_dom", 32'(domain_rst_n), 0);

    // soft_rst and lock loss in the same RUN cycle.
    wait_ph(P_RUN, 2, "simul_run");
    exp_loss = m_loss;
    pll_locked = 1'b0; tick(); tick();
    soft_rst = 1'b1; tick(); soft_rst = 1'b0;
    chk("simul_state", 32'(state), P_RST);
    chk("simul_retry", 32'(retry_cnt), 0);
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    chk("simul_loss", 32'(lock_loss_cnt), 32'(exp_loss));
`endif

    // Randomized traffic with one asynchronous reset mid-run.
    run_left = 0;
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", 32'(state), P_RST);
        chk("async_pll_rst", 32'(pll_rst), 1);
        chk("async_dom", 32'(domain_rst_n), 0);
        m_reset();
        tick(); tick();
        rst_n = 1'b1;
      end
      if (run_left == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        run_left = pll_locked ? $urandom_range(1, 60) : $urandom_range(1, 40);
      end
      run_left--;
      soft_rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    soft_rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Parametrised lock-qualification and reset-sequencing controller that sits beside the system PLL in the refclk domain.
- Drives the PLL reset, synchronises and debounces the PLL lock, and retries on lock timeout.
- Releases NUM_CH downstream domain resets in a staggered order, and tears all of them down on lock loss or soft reset.
- Generalises the bare lock output into a managed bring-up sequence for any number of clock consumers.

Parameters:
- NUM_CH, 2, number of downstream domain resets (>=1)
- PLL_RST_CYC, 16, cycles pll_rst is held high per reset attempt (>=1)
- LOCK_STABLE_CYC, 1024, consecutive synchronised-lock cycles required before lock is qualified (>=1)
- LOCK_TIMEOUT_CYC, 65536, cycles to wait for lock before a retry (>=2)
- STAGGER_CYC, 8, cycles between successive domain reset releases (>=1)
- MAX_RETRY, 3, failed lock attempts before FAULT (>=1)
- SYNC_STAGES, 2, flops in the pll_locked synchroniser (>=2)

Ports:
- refclk  in  1  free-running reference clock; sole clock
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  raw PLL lock, asynchronous to refclk
- soft_rst  in  1  synchronous restart request, sampled each cycle
- pll_rst  out  1  active-high reset to the PLL
- domain_rst_n  out  NUM_CH  per-domain active-low resets; bit 0 released first
- locked  out  1  qualified lock
- fault  out  1  retry budget exhausted
- state  out  3  current FSM state encoding, for debug
- retry_cnt  out  $clog2(MAX_RETRY+1)  failed attempts since the last qualified lock

Behaviour:
- Reset values while rst_n is low:
  - pll_rst=1, domain_rst_n=0, locked=0, fault=0, retry_cnt=0
  - state=PLL_RST, all counters 0, synchroniser flops 0
- Lock synchroniser: pll_locked passes through SYNC_STAGES flops to give lock_s. Latency is SYNC_STAGES cycles.
- State encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAULT=5. All outputs are registered.
- PLL_RST:
  - pll_rst=1 for exactly PLL_RST_CYC cycles, then go to WAIT_LOCK.
  - pll_rst falls in the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - Timeout counter runs from 0.
  - lock_s=1 -> STABLE.
  - Counter reaches LOCK_TIMEOUT_CYC-1 with lock_s=0 -> retry_cnt+1. If the new value equals MAX_RETRY -> FAULT, else -> PLL_RST.
- STABLE:
  - Counts consecutive lock_s=1 cycles.
  - Any lock_s=0 -> WAIT_LOCK; the timeout counter restarts from 0.
  - Count reaches LOCK_STABLE_CYC -> RELEASE. locked=1 and retry_cnt=0 in the same cycle.
- RELEASE:
  - domain_rst_n[i] rises i*STAGGER_CYC cycles after RELEASE entry; bit 0 rises in the entry cycle.
  - Once bit NUM_CH-1 has risen -> RUN.
  - With NUM_CH=1, RELEASE lasts one cycle.
  - Released bits stay high until a teardown.
- RUN: all domain resets high, locked=1; holds indefinitely.
- Lock loss: lock_s=0 in RELEASE or RUN causes a teardown on the next edge: all domain_rst_n=0, locked=0, state -> PLL_RST, retry_cnt unchanged (0).
- FAULT:
  - pll_rst=1, all domain_rst_n=0, locked=0, fault=1.
  - Only soft_rst or rst_n exits FAULT.
- soft_rst:
  - Valid in any state.
  - Next edge: state=PLL_RST, retry_cnt=0, fault=0, all counters cleared, outputs as for reset.
- Priority per cycle: soft_rst > lock loss > timer expiry.
- rst_n asserted mid-sequence clears everything asynchronously. Deassertion restarts at PLL_RST.
- Counter widths: $clog2 of the largest parameter they count to. No wrap occurs; every counter is cleared on each state entry.

Optional Feature:
- Macro: PLL_RESET_SEQUENCER_LOSS_CNT_EN.
- When defined:
  - Adds output port lock_loss_cnt (16 bits) counting lock-loss teardowns from RELEASE/RUN.
  - The counter saturates at 16'hFFFF.
  - It is cleared by rst_n only; soft_rst does not clear it.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pll_reset_sequencer_pkg holds:
  - the state enum typedef with fixed encodings 0..5
  - a localparam width helper function (clog2-based)
  - the lock-loss counter width (16)
- One sub-module, sync_bit: parametrised SYNC_STAGES flop chain with async active-low reset, used for pll_locked.

Test Plan:
All scenarios use NUM_CH=3, PLL_RST_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, STAGGER_CYC=3, MAX_RETRY=2, SYNC_STAGES=2.
- Bring-up:
  - Stimulus: rst_n released; pll_locked rises at cycle 10.
  - Response: pll_rst high cycles 0-3, low from 4. locked=1 eight cycles after lock_s rises. domain_rst_n = 001, 011, 111 at +0/+3/+6. state=4 afterwards.
- Timeout retry:
  - Stimulus: pll_locked held 0.
  - Response: retry_cnt=1 after the first 32-cycle wait, pll_rst re-pulses for 4 cycles. Second timeout gives fault=1, state=5, retry_cnt=2.
- Glitchy lock:
  - Stimulus: lock_s drops after 5 good cycles in STABLE.
  - Response: state returns to 1, locked stays 0, domain_rst_n stays 000.
- Lock loss in RUN:
  - Stimulus: pll_locked falls.
  - Response: SYNC_STAGES+1 cycles later domain_rst_n=000, locked=0, state=0, pll_rst=1. With the macro defined, lock_loss_cnt increments 0->1.
- Soft reset from FAULT:
  - Stimulus: 1-cycle soft_rst pulse.
  - Response: next cycle fault=0, retry_cnt=0, state=0; a normal bring-up follows.
- Simultaneous events:
  - Stimulus: soft_rst and lock loss in the same RUN cycle.
  - Response: soft_rst path taken; retry_cnt=0 and lock_loss_cnt unchanged.
